// File: rtl/inst_encoder_pkg.sv
// Shared definitions for the RV32I streaming encoder: op codes, error codes,
// RV32I opcode/funct fields and the encoder FSM state type.
package inst_encoder_pkg;

  // Symbolic op selector on in_op
  localparam logic [2:0] OP_ADD  = 3'd0;
  localparam logic [2:0] OP_SUB  = 3'd1;
  localparam logic [2:0] OP_AND  = 3'd2;
  localparam logic [2:0] OP_OR   = 3'd3;
  localparam logic [2:0] OP_ADDI = 3'd4;
  localparam logic [2:0] OP_LUI  = 3'd5;
  localparam logic [2:0] OP_JAL  = 3'd6;

  // First-error codes reported on err_code
  localparam logic [1:0] ERR_NONE  = 2'd0;
  localparam logic [1:0] ERR_BADOP = 2'd1;
  localparam logic [1:0] ERR_RANGE = 2'd2;
  localparam logic [1:0] ERR_ALIGN = 2'd3;

  // RV32I major opcodes and function fields, same layout as the decoder
  localparam logic [6:0] OPCODE_OP     = 7'b0110011;
  localparam logic [6:0] OPCODE_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPCODE_LUI    = 7'b0110111;
  localparam logic [6:0] OPCODE_JAL    = 7'b1101111;

  localparam logic [2:0] FUNCT3_ADD_SUB = 3'b000;
  localparam logic [2:0] FUNCT3_AND     = 3'b111;
  localparam logic [2:0] FUNCT3_OR      = 3'b110;

  localparam logic [6:0] FUNCT7_BASE = 7'b0000000;
  localparam logic [6:0] FUNCT7_SUB  = 7'b0100000;

  // Encoder FSM states
  typedef enum logic [1:0] {
    ENC_IDLE  = 2'd0,
    ENC_RUN   = 2'd1,
    ENC_DRAIN = 2'd2,
    ENC_DONE  = 2'd3
  } enc_state_e;

endpackage

// File: rtl/inst_field_pack.sv
// Combinational packer: turns one symbolic op into a 32-bit RV32I word and
// reports whether the op is legal (err_code == ERR_NONE) or why it is not.
module inst_field_pack
  import inst_encoder_pkg::*;
(
  input  logic [2:0]  op,
  input  logic [4:0]  rd,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  input  logic [31:0] imm,
  output logic [31:0] word,
  output logic [1:0]  err_code
);

  // ADDI immediate fits the signed 12-bit field when bits 31..11 are a pure sign extension
  logic addi_in_range;
  // JAL offset fits the signed 21-bit field when bits 31..20 are a pure sign extension
  logic jal_in_range;

  assign addi_in_range = (&imm[31:11]) || (~|imm[31:11]);
  assign jal_in_range  = (&imm[31:20]) || (~|imm[31:20]);

  // Field packing and legality check; priority is bad op, then range, then alignment
  always_comb begin
    word     = 32'h0;
    err_code = ERR_NONE;
    case (op)
      OP_ADD:  word = {FUNCT7_BASE, rs2, rs1, FUNCT3_ADD_SUB, rd, OPCODE_OP};
      OP_SUB:  word = {FUNCT7_SUB,  rs2, rs1, FUNCT3_ADD_SUB, rd, OPCODE_OP};
      OP_AND:  word = {FUNCT7_BASE, rs2, rs1, FUNCT3_AND,     rd, OPCODE_OP};
      OP_OR:   word = {FUNCT7_BASE, rs2, rs1, FUNCT3_OR,      rd, OPCODE_OP};
      OP_ADDI: begin
        word = {imm[11:0], rs1, FUNCT3_ADD_SUB, rd, OPCODE_OP_IMM};
        if (!addi_in_range) err_code = ERR_RANGE;
      end
      OP_LUI: begin
        word = {imm[31:12], rd, OPCODE_LUI};
        if (imm[11:0] != 12'h0) err_code = ERR_ALIGN;
      end
      OP_JAL: begin
        word = {imm[20], imm[10:1], imm[11], imm[19:12], rd, OPCODE_JAL};
        if (!jal_in_range)  err_code = ERR_RANGE;
        else if (imm[0])    err_code = ERR_ALIGN;
      end
      default: err_code = ERR_BADOP;
    endcase
  end

endmodule

// File: rtl/inst_encoder.sv
// Streaming RV32I encoder / program loader. Accepts symbolic ops over a
// valid/ready handshake and writes the packed words to consecutive imem
// byte addresses starting at a latched base address.
//
// Handshakes: an op transfers on a rising edge where in_valid && in_ready;
// a word transfers on a rising edge where mem_we && mem_ready. While a word
// is offered and not taken, mem_we/mem_addr/mem_wdata are held stable and
// in_ready stays low, so a new op is taken only when the output register is
// empty or is being emptied on the same edge.
module inst_encoder
  import inst_encoder_pkg::*;
#(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        in_op,
  input  logic [4:0]        in_rd,
  input  logic [4:0]        in_rs1,
  input  logic [4:0]        in_rs2,
  input  logic [31:0]       in_imm,
  input  logic              in_last,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic              mem_ready,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [1:0]        err_code,
  output logic [ADDR_W-1:0] word_count
);

  enc_state_e        state_q;
  enc_state_e        state_d;
  logic [ADDR_W-1:0] next_addr;   // address the next accepted word will be written to
  logic [31:0]       pack_word;
  logic [1:0]        pack_err;
  logic              accept;
  logic              wr_hs;
  logic              op_ok;

  inst_field_pack u_pack (
    .op       (in_op),
    .rd       (in_rd),
    .rs1      (in_rs1),
    .rs2      (in_rs2),
    .imm      (in_imm),
    .word     (pack_word),
    .err_code (pack_err)
  );

  assign in_ready = (state_q == ENC_RUN) && (!mem_we || mem_ready);
  assign accept   = in_valid && in_ready;
  assign wr_hs    = mem_we && mem_ready;
  assign op_ok    = (pack_err == ERR_NONE);
  assign busy     = (state_q != ENC_IDLE);
  assign done     = (state_q == ENC_DONE);

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ENC_IDLE;
    else        state_q <= state_d;
  end

  // Next state: DRAIN waits until the output register has been emptied
  always_comb begin
    state_d = state_q;
    case (state_q)
      ENC_IDLE:  if (start)              state_d = ENC_RUN;
      ENC_RUN:   if (accept && in_last)  state_d = ENC_DRAIN;
      ENC_DRAIN: if (!mem_we)            state_d = ENC_DONE;
      ENC_DONE:                          state_d = ENC_IDLE;
      default:                           state_d = ENC_IDLE;
    endcase
  end

  // Output register, write address, word counter and sticky error
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= 32'h0;
      next_addr  <= '0;
      word_count <= '0;
      err        <= 1'b0;
      err_code   <= ERR_NONE;
    end else begin
      if ((state_q == ENC_IDLE) && start) begin
        next_addr  <= {base_addr[ADDR_W-1:2], 2'b00};
        word_count <= '0;
        err        <= 1'b0;
        err_code   <= ERR_NONE;
      end
      if (accept && op_ok) begin
        mem_we    <= 1'b1;
        mem_addr  <= next_addr;
        mem_wdata <= pack_word;
        next_addr <= next_addr + ADDR_W'(4);
      end else if (wr_hs) begin
        mem_we <= 1'b0;
      end
      if (wr_hs) word_count <= word_count + ADDR_W'(1);
      if (accept && !op_ok) begin
        err <= 1'b1;
        if (err_code == ERR_NONE) err_code <= pack_err;
      end
    end
  end

endmodule

// File: tb/tb_inst_encoder.sv
// Directed bench for inst_encoder: table of encodings streamed back-to-back,
// table of rejected ops, plus hand-written stall, wrap, error-priority and
// mid-program reset sequences.
module tb_inst_encoder;

  localparam int ADDR_W = 10;
  localparam int W      = ADDR_W + 32;

  logic              clk;
  logic              rst_n;
  logic              start;
  logic [ADDR_W-1:0] base_addr;
  logic              in_valid;
  logic              in_ready;
  logic [2:0]        in_op;
  logic [4:0]        in_rd;
  logic [4:0]        in_rs1;
  logic [4:0]        in_rs2;
  logic [31:0]       in_imm;
  logic              in_last;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic              mem_ready;
  logic              busy;
  logic              done;
  logic              err;
  logic [1:0]        err_code;
  logic [ADDR_W-1:0] word_count;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  logic [W-1:0] exp_q[$];

  typedef struct {
    logic [2:0]  op;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] imm;
    logic [31:0] exp_word;
  } vec_t;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] imm;
    logic [1:0]  exp_code;
  } err_vec_t;

  vec_t     vecs[11];
  err_vec_t evecs[8];

  inst_encoder #(.ADDR_W(ADDR_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .base_addr  (base_addr),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_op      (in_op),
    .in_rd      (in_rd),
    .in_rs1     (in_rs1),
    .in_rs2     (in_rs2),
    .in_imm     (in_imm),
    .in_last    (in_last),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_ready  (mem_ready),
    .busy       (busy),
    .done       (done),
    .err        (err),
    .err_code   (err_code),
    .word_count (word_count)
  );

  // clock / cycle counter
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // scoreboard: every write handshake must match the head of exp_q
  always @(negedge clk) begin
    if (rst_n && mem_we && mem_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_write: addr 0x%03h data 0x%08h, none expected", mem_addr, mem_wdata);
      end else begin
        logic [W-1:0] e;
        e = exp_q.pop_front();
        chk("write_addr", 32'(mem_addr), 32'(e[W-1:32]));
        chk("write_data", mem_wdata, e[31:0]);
      end
    end
  end

  task automatic push_exp(input logic [ADDR_W-1:0] a, input logic [31:0] d);
    exp_q.push_back({a, d});
  endtask

  // drivers: all tasks return at posedge + 1
  task automatic do_start(input logic [ADDR_W-1:0] b);
    @(posedge clk); #1;
    start = 1'b1;
    base_addr = b;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic send_op(input logic [2:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                         input logic [4:0] rs2, input logic [31:0] imm, input logic last);
    int n;
    in_op = op; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2; in_imm = imm; in_last = last;
    in_valid = 1'b1;
    n = 0;
    forever begin
      @(negedge clk);
      if (in_ready) break;
      n++;
      if (n > 50) begin
        checks++;
        failures++;
        $display("FAIL send_timeout: in_ready 0 after %0d cycles, expected 1", n);
        break;
      end
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic wait_done();
    int n;
    logic got;
    got = 1'b0;
    for (n = 0; n < 30; n++) begin
      @(negedge clk);
      if (done) begin
        got = 1'b1;
        break;
      end
    end
    chk("done_seen", 32'(got), 32'd1);
  endtask

  initial begin
    int t0;
    vecs[0]  = '{3'd4, 5'd1, 5'd0, 5'd0,  32'd5,          32'h00500093};
    vecs[1]  = '{3'd0, 5'd3, 5'd1, 5'd2,  32'd0,          32'h002081B3};
    vecs[2]  = '{3'd1, 5'd3, 5'd1, 5'd2,  32'd0,          32'h402081B3};
    vecs[3]  = '{3'd2, 5'd4, 5'd1, 5'd2,  32'd0,          32'h0020F233};
    vecs[4]  = '{3'd3, 5'd4, 5'd1, 5'd2,  32'd0,          32'h0020E233};
    vecs[5]  = '{3'd5, 5'd5, 5'd7, 5'd9,  32'h12345000,   32'h123452B7};
    vecs[6]  = '{3'd4, 5'd2, 5'd1, 5'd31, 32'hFFFFFFFF,   32'hFFF08113};
    vecs[7]  = '{3'd4, 5'd1, 5'd0, 5'd0,  32'd2047,       32'h7FF00093};
    vecs[8]  = '{3'd4, 5'd1, 5'd0, 5'd0,  32'hFFFFF800,   32'h80000093};
    vecs[9]  = '{3'd6, 5'd0, 5'd3, 5'd4,  32'hFFFFFFFC,   32'hFFDFF06F};
    vecs[10] = '{3'd6, 5'd1, 5'd0, 5'd0,  32'd8,          32'h008000EF};

    evecs[0] = '{3'd7, 32'd0,        2'd1};
    evecs[1] = '{3'd4, 32'd2048,     2'd2};
    evecs[2] = '{3'd4, 32'hFFFFF7FF, 2'd2};
    evecs[3] = '{3'd6, 32'h00100000, 2'd2};
    evecs[4] = '{3'd6, 32'hFFEFFFFE, 2'd2};
    evecs[5] = '{3'd6, 32'd3,        2'd3};
    evecs[6] = '{3'd6, 32'h000FFFFF, 2'd3};
    evecs[7] = '{3'd5, 32'h12345001, 2'd3};

    rst_n = 1'b0; start = 1'b0; base_addr = '0; in_valid = 1'b0;
    in_op = '0; in_rd = '0; in_rs1 = '0; in_rs2 = '0; in_imm = '0; in_last = 1'b0;
    mem_ready = 1'b1;

    // reset state
    #1;
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_mem_we", 32'(mem_we), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_word_count", 32'(word_count), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // start outside IDLE check is implicit; in_valid in IDLE must not be taken
    @(negedge clk);
    chk("idle_in_ready", 32'(in_ready), 32'd0);

    // encoding table streamed back-to-back from base 0x040
    do_start(10'h040);
    chk("run_busy", 32'(busy), 32'd1);
    t0 = cyc;
    for (int i = 0; i < 11; i++) begin
      push_exp(10'(10'h040 + 4 * i), vecs[i].exp_word);
      send_op(vecs[i].op, vecs[i].rd, vecs[i].rs1, vecs[i].rs2, vecs[i].imm, i == 10);
    end
    chk("stream_cycles", 32'(cyc - t0), 32'd11);
    chk("drain_done0", 32'(done), 32'd0);
    @(posedge clk); #1;
    chk("drain_done1", 32'(done), 32'd0);
    @(posedge clk); #1;
    chk("done_pulse", 32'(done), 32'd1);
    @(posedge clk); #1;
    chk("done_cleared", 32'(done), 32'd0);
    chk("idle_busy", 32'(busy), 32'd0);
    chk("stream_word_count", 32'(word_count), 32'd11);
    chk("stream_err", 32'(err), 32'd0);

    // rejected ops: one-op programs, nothing written
    for (int i = 0; i < 8; i++) begin
      do_start(10'h100);
      send_op(evecs[i].op, 5'd1, 5'd2, 5'd3, evecs[i].imm, 1'b1);
      wait_done();
      chk("rej_err", 32'(err), 32'd1);
      chk("rej_err_code", 32'(err_code), 32'(evecs[i].exp_code));
      chk("rej_word_count", 32'(word_count), 32'd0);
    end

    // first error latches: range, then bad op, then a good ADDI
    do_start(10'h100);
    send_op(3'd4, 5'd1, 5'd0, 5'd0, 32'd2048, 1'b0);
    send_op(3'd7, 5'd1, 5'd0, 5'd0, 32'd0, 1'b0);
    push_exp(10'h100, 32'h00500093);
    send_op(3'd4, 5'd1, 5'd0, 5'd0, 32'd5, 1'b1);
    wait_done();
    chk("prio_err", 32'(err), 32'd1);
    chk("prio_err_code", 32'(err_code), 32'd2);
    chk("prio_word_count", 32'(word_count), 32'd1);

    // back-pressure: outputs held for 5 stalled cycles
    mem_ready = 1'b0;
    do_start(10'h200);
    chk("start_clears_err", 32'(err), 32'd0);
    push_exp(10'h200, 32'h002081B3);
    push_exp(10'h204, 32'h402081B3);
    send_op(3'd0, 5'd3, 5'd1, 5'd2, 32'd0, 1'b0);
    in_op = 3'd1; in_rd = 5'd3; in_rs1 = 5'd1; in_rs2 = 5'd2; in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("stall_mem_we", 32'(mem_we), 32'd1);
      chk("stall_addr", 32'(mem_addr), 32'h200);
      chk("stall_data", mem_wdata, 32'h002081B3);
      chk("stall_in_ready", 32'(in_ready), 32'd0);
    end
    @(posedge clk); #1;
    mem_ready = 1'b1;
    send_op(3'd1, 5'd3, 5'd1, 5'd2, 32'd0, 1'b1);
    wait_done();
    chk("stall_word_count", 32'(word_count), 32'd2);

    // address wrap, low base bits ignored
    do_start(10'h3FF);
    push_exp(10'h3FC, 32'h00500093);
    push_exp(10'h000, 32'h00500113);
    send_op(3'd4, 5'd1, 5'd0, 5'd0, 32'd5, 1'b0);
    send_op(3'd4, 5'd2, 5'd0, 5'd0, 32'd5, 1'b1);
    wait_done();
    chk("wrap_word_count", 32'(word_count), 32'd2);

    // reset while a write is pending
    do_start(10'h010);
    send_op(3'd7, 5'd0, 5'd0, 5'd0, 32'd0, 1'b0);
    mem_ready = 1'b0;
    send_op(3'd0, 5'd3, 5'd1, 5'd2, 32'd0, 1'b0);
    chk("pre_rst_mem_we", 32'(mem_we), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("arst_mem_we", 32'(mem_we), 32'd0);
    chk("arst_mem_addr", 32'(mem_addr), 32'd0);
    chk("arst_mem_wdata", mem_wdata, 32'd0);
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_err", 32'(err), 32'd0);
    chk("arst_err_code", 32'(err_code), 32'd0);
    chk("arst_in_ready", 32'(in_ready), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    mem_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("post_rst_idle", 32'(mem_we), 32'd0);

    chk("exp_q_empty", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
